// File: rtl/mont_exp.sv
// rtl/mont_exp.sv - modular exponentiation sequencer driving an external Montgomery multiplier
// Left-to-right square-and-multiply: every op issues to mont, then releases until mm_done falls.

module mont_exp #(
  parameter int n_bit = 7,
  parameter int e_bit = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [n_bit-1:0] m,
  input  logic [e_bit-1:0] e,
  input  logic [n_bit-1:0] r2,
  output logic [n_bit-1:0] c,
  output logic             done,
  output logic             busy,
  output logic [n_bit-1:0] mm_x,
  output logic [n_bit-1:0] mm_y,
  output logic             mm_start,
  input  logic [n_bit-1:0] mm_z,
  input  logic             mm_done
);

  localparam int cw = $clog2(e_bit) + 1;
  localparam logic [n_bit-1:0] one_v = n_bit'(1);

  typedef enum logic [2:0] {IDLE, PRE_M, PRE_A, SQR, MUL, POST, FIN} state_t;

  state_t           state_q, state_d;
  logic             rel_q, rel_d;
  logic [n_bit-1:0] acc_q, acc_d, mb_q, mb_d, m_q, m_d, r2_q, r2_d, c_q, c_d;
  logic [e_bit-1:0] esh_q, esh_d;
  logic [cw-1:0]    cnt_q, cnt_d;
  logic             in_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rel_q   <= 1'b0;
      acc_q   <= '0;
      mb_q    <= '0;
      m_q     <= '0;
      r2_q    <= '0;
      c_q     <= '0;
      esh_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      acc_q   <= acc_d;
      mb_q    <= mb_d;
      m_q     <= m_d;
      r2_q    <= r2_d;
      c_q     <= c_d;
      esh_q   <= esh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rel_d    = rel_q;
    acc_d    = acc_q;
    mb_d     = mb_q;
    m_d      = m_q;
    r2_d     = r2_q;
    c_d      = c_q;
    esh_d    = esh_q;
    cnt_d    = cnt_q;
    mm_x     = '0;
    mm_y     = '0;
    mm_start = 1'b0;
    done     = 1'b0;
    in_op    = 1'b1;

    case (state_q)
      IDLE: begin
        in_op = 1'b0;
        if (start) begin
          m_d     = m;
          r2_d    = r2;
          esh_d   = e;
          cnt_d   = cw'(e_bit);
          rel_d   = 1'b0;
          state_d = PRE_M;
        end
      end
      PRE_M: begin mm_x = m_q;   mm_y = r2_q;  end
      PRE_A: begin mm_x = one_v; mm_y = r2_q;  end
      SQR:   begin mm_x = acc_q; mm_y = acc_q; end
      MUL:   begin mm_x = acc_q; mm_y = mb_q;  end
      POST:  begin mm_x = acc_q; mm_y = one_v; end
      FIN: begin
        in_op   = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        in_op   = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (in_op) begin
      if (!rel_q) begin
        mm_start = 1'b1;
        if (mm_done) begin
          rel_d = 1'b1;
          if (state_q == PRE_M) mb_d = mm_z;
          else                  acc_d = mm_z;
        end
      end else if (!mm_done) begin
        rel_d = 1'b0;
        // A bit is consumed after its SQR when it is 0, or after its MUL when it is 1.
        case (state_q)
          PRE_M: state_d = PRE_A;
          PRE_A: state_d = SQR;
          SQR, MUL: begin
            if (state_q == SQR && esh_q[e_bit-1]) begin
              state_d = MUL;
            end else begin
              esh_d   = esh_q << 1;
              cnt_d   = cnt_q - cw'(1);
              state_d = (cnt_q == cw'(1)) ? POST : SQR;
            end
          end
          POST: begin
            c_d     = acc_q;
            state_d = FIN;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign c    = c_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mont_exp.sv
// tb/tb_mont_exp.sv - directed-vector bench for mont_exp with a behavioural Montgomery responder mod 79
// Responder: z = x*y*2^-9 mod 79 (2^-9 == 52 mod 79), done raised in issue cycle lat+1.

module tb_mont_exp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] m = '0, e = '0, r2 = 7'd22;
  logic [6:0] c, mm_x, mm_y, mm_z;
  logic       done, busy, mm_start, mm_done;

  mont_exp #(.n_bit(7), .e_bit(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .e(e), .r2(r2),
    .c(c), .done(done), .busy(busy),
    .mm_x(mm_x), .mm_y(mm_y), .mm_start(mm_start), .mm_z(mm_z), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  int  cnt = 0, lat = 3;
  bit  rand_lat = 1'b0;
  assign mm_done = mm_start && (cnt == lat);
  assign mm_z    = 7'((int'(mm_x) * int'(mm_y) * 52) % 79);

  always @(posedge clk) begin
    if (!mm_start) begin
      cnt <= 0;
      lat <= rand_lat ? int'($urandom_range(8, 0)) : 3;
    end else begin
      cnt <= cnt + 1;
    end
  end

  int         rise_cnt = 0, done_cnt = 0, stab_err = 0, gap_err = 0;
  logic       p_start = 1'b0, p_done = 1'b0;
  logic [6:0] p_x = '0, p_y = '0;
  always @(posedge clk) begin
    if (mm_start && !p_start) rise_cnt <= rise_cnt + 1;
    if (mm_start && p_start && (mm_x != p_x || mm_y != p_y)) stab_err <= stab_err + 1;
    if (mm_start && p_start && p_done) gap_err <= gap_err + 1;
    if (done) done_cnt <= done_cnt + 1;
    p_start <= mm_start;
    p_done  <= mm_done;
    p_x     <= mm_x;
    p_y     <= mm_y;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_exp(input logic [6:0] mv, input logic [6:0] ev,
                         output int cv, output int cyc, output int ops, output int got);
    int base;
    @(negedge clk);
    m = mv; e = ev; start = 1'b1;
    base = rise_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    got = int'(done);
    cv  = int'(c);
    ops = rise_cnt - base;
  endtask

  typedef struct {
    logic [6:0] mv;
    logic [6:0] ev;
    int         exp_c;
    int         exp_ops;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cv, cyc, ops, got, base, w;

    vecs[0] = '{7'd17, 7'd5,   69, 12, 61};
    vecs[1] = '{7'd2,  7'd127, 76, 17, 86};
    vecs[2] = '{7'd20, 7'd1,   20, 11, 56};
    vecs[3] = '{7'd45, 7'd0,    1, 10, 51};
    vecs[4] = '{7'd0,  7'd3,    0, 12, 61};

    #12;
    check("reset c", int'(c), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    check("reset mm_start", int'(mm_start), 0);
    check("reset mm_x", int'(mm_x), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_exp(vecs[i].mv, vecs[i].ev, cv, cyc, ops, got);
      check($sformatf("vec%0d c", i), cv, vecs[i].exp_c);
      check($sformatf("vec%0d ops", i), ops, vecs[i].exp_ops);
      check($sformatf("vec%0d latency", i), cyc, vecs[i].exp_cyc);
      @(posedge clk); #1;
      check($sformatf("vec%0d busy after done", i), int'(busy), 0);
    end

    // Second start while busy must be ignored.
    base = done_cnt;
    @(negedge clk);
    m = 7'd17; e = 7'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    m = 7'd3; e = 7'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 3000) begin @(posedge clk); #1; w++; end
    check("ignored start c", int'(c), 69);
    repeat (80) @(posedge clk);
    #1;
    check("ignored start done count", done_cnt - base, 1);
    check("ignored start c held", int'(c), 69);

    // Random responder latency with handshake checks.
    rand_lat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stab_err = 0; gap_err = 0;
      run_exp(7'd17, 7'd5, cv, cyc, ops, got);
      check($sformatf("rand%0d done", k), got, 1);
      check($sformatf("rand%0d c", k), cv, 69);
      check($sformatf("rand%0d ops", k), ops, 12);
      check($sformatf("rand%0d operand stable", k), stab_err, 0);
      check($sformatf("rand%0d release gap", k), gap_err, 0);
    end
    rand_lat = 1'b0;
    repeat (2) @(posedge clk);

    // Reset asserted during the third SQR (fifth op).
    @(negedge clk);
    m = 7'd17; e = 7'd5; start = 1'b1;
    base = rise_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (rise_cnt - base < 5 && w < 200) begin @(posedge clk); #1; w++; end
    check("reached third SQR", rise_cnt - base, 5);
    @(negedge clk);
    check("mid-op mm_start high", int'(mm_start), 1);
    rst_n = 1'b0;
    #1;
    check("async rst mm_start", int'(mm_start), 0);
    check("async rst done", int'(done), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst c", int'(c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_exp(7'd17, 7'd5, cv, cyc, ops, got);
    check("post-reset c", cv, 69);
    check("post-reset latency", cyc, 61);
    check("post-reset ops", ops, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
